// File: rtl/ddr3_pkg.sv
// Shared command codes, command-word layout and FSM state type for the DDR3 host front end.
// No logic of its own; pack_cmd is pure combinational.
// Backpressure: not applicable.
package ddr3_pkg;

   localparam logic [2:0] CMD_SCR = 3'b001;
   localparam logic [2:0] CMD_SCW = 3'b010;

   // Command-word field positions (LSB of each field)
   localparam int CW_WIDTH   = 34;
   localparam int CW_CMD_LSB = 31;
   localparam int CW_BA_LSB  = 28;
   localparam int CW_ROW_LSB = 15;
   localparam int CW_COL_LSB = 5;
   localparam int CW_TAG_LSB = 0;

   localparam int BURST_DEFAULT = 8;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_WDATA = 2'd1,
      ST_PUSH  = 2'd2
   } fe_state_t;

   // addr is {BA[2:0], row[12:0], col[9:0]}
   function automatic logic [CW_WIDTH-1:0] pack_cmd(input logic [2:0]  cmd,
                                                    input logic [25:0] addr,
                                                    input logic [4:0]  tag);
      logic [CW_WIDTH-1:0] word;
      word = '0;
      word[CW_CMD_LSB +: 3]  = cmd;
      word[CW_BA_LSB  +: 3]  = addr[25:23];
      word[CW_ROW_LSB +: 13] = addr[22:10];
      word[CW_COL_LSB +: 10] = addr[9:0];
      word[CW_TAG_LSB +: 5]  = tag;
      return word;
   endfunction

endpackage

// File: rtl/ddr3_host_frontend_if.sv
// Host request and write-data handshake bundle for the DDR3 front end.
// Pure wiring, no latency.
// Backpressure: host_cmd_ready / host_wdata_ready driven by the slave side.
interface ddr3_host_frontend_if;
   logic        host_cmd_valid;
   logic        host_cmd_ready;
   logic [2:0]  host_cmd;
   logic [25:0] host_addr;
   logic [4:0]  host_tag;
   logic        host_wdata_valid;
   logic        host_wdata_ready;
   logic [15:0] host_wdata;
   logic        host_err;

   modport master (
      output host_cmd_valid, host_cmd, host_addr, host_tag,
      output host_wdata_valid, host_wdata,
      input  host_cmd_ready, host_wdata_ready, host_err
   );

   modport slave (
      input  host_cmd_valid, host_cmd, host_addr, host_tag,
      input  host_wdata_valid, host_wdata,
      output host_cmd_ready, host_wdata_ready, host_err
   );
endinterface

// File: rtl/ddr3_sync_fifo.sv
// Synchronous FIFO with registered read port, occupancy count and registered full/empty.
// Pop data appears one cycle after a successful pop and holds until the next one.
// Backpressure: push ignored while full, pop ignored while empty.
module ddr3_sync_fifo #(
   parameter  int WIDTH = 16,
   parameter  int DEPTH = 8,
   localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
   localparam int CW    = $clog2(DEPTH) + 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic [WIDTH-1:0] push_dat,
   input  logic             pop,
   output logic [WIDTH-1:0] pop_dat,
   output logic [CW-1:0]    count,
   output logic             full,
   output logic             empty
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic             full_q, full_d, empty_q, empty_d;
   logic [WIDTH-1:0] rd_dat_q, rd_dat_d;
   logic             do_push, do_pop;

   // Next pointers, count and flags; flags derive from the next count so they track the edge
   always_comb begin
      do_push  = push && !full_q;
      do_pop   = pop && !empty_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      rd_dat_d = rd_dat_q;
      count_d  = count_q;
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
         rd_dat_d = mem_q[rd_ptr_q];
      end
      case ({do_push, do_pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
      full_d  = (count_d == CW'(DEPTH));
      empty_d = (count_d == '0);
   end

   // Storage array, no reset needed
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= push_dat;
   end

   // Control state register
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         full_q   <= 1'b0;
         empty_q  <= 1'b1;
         rd_dat_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         full_q   <= full_d;
         empty_q  <= empty_d;
         rd_dat_q <= rd_dat_d;
      end
   end

   assign pop_dat = rd_dat_q;
   assign count   = count_q;
   assign full    = full_q;
   assign empty   = empty_q;

endmodule

// File: rtl/ddr3_host_frontend.sv
// Host front end: packs SCR/SCW requests into command words, buffers commands and write beats.
// Read visible in CMD FIFO 1 cycle after accept; write 2 cycles after its last beat.
// Backpressure: cmd ready only in IDLE with a free command slot and BURST free data slots.
// Optional statistics counters built when DDR3_FE_STATS_EN is defined.
module ddr3_host_frontend
   import ddr3_pkg::*;
#(
   parameter int CMD_DEPTH  = 8,
   parameter int DATA_DEPTH = 64,
   parameter int BURST      = BURST_DEFAULT
) (
   input  logic                 clk,
   input  logic                 reset,
   ddr3_host_frontend_if.slave  host,
   input  logic                 CMD_get,
   output logic                 CMD_empty,
   output logic [CW_WIDTH-1:0]  CMD_data_out,
   input  logic                 DATA_get,
   output logic [15:0]          DATA_data_out,
   output logic [15:0]          stat_rd_cnt,
   output logic [15:0]          stat_wr_cnt
);

   localparam int BW  = (BURST > 1) ? $clog2(BURST) : 1;
   localparam int CCW = $clog2(CMD_DEPTH) + 1;
   localparam int DCW = $clog2(DATA_DEPTH) + 1;

   fe_state_t           state_q, state_d;
   logic [CW_WIDTH-1:0] hold_q, hold_d;
   logic [BW-1:0]       beat_q, beat_d;
   logic                err_q, err_d;

   logic                cmd_push, dat_push, cmd_rdy, wdat_rdy, rd_acc, wr_done;
   logic [CW_WIDTH-1:0] cmd_push_dat;
   logic                cmd_full;
   logic [DCW-1:0]      data_count, data_free;
   logic [CCW-1:0]      unused_cmd_count;
   logic                unused_data_full, unused_data_empty;

   assign data_free = DCW'(DATA_DEPTH) - data_count;

   // Request FSM: next state, FIFO pushes and handshake readies
   always_comb begin
      state_d      = state_q;
      hold_d       = hold_q;
      beat_d       = beat_q;
      err_d        = 1'b0;
      cmd_push     = 1'b0;
      cmd_push_dat = hold_q;
      dat_push     = 1'b0;
      cmd_rdy      = 1'b0;
      wdat_rdy     = 1'b0;
      rd_acc       = 1'b0;
      wr_done      = 1'b0;
      case (state_q)
         ST_IDLE: begin
            cmd_rdy = !reset && !cmd_full && (data_free >= DCW'(BURST));
            if (host.host_cmd_valid && cmd_rdy) begin
               case (host.host_cmd)
                  CMD_SCR: begin
                     cmd_push     = 1'b1;
                     cmd_push_dat = pack_cmd(host.host_cmd, host.host_addr, host.host_tag);
                     rd_acc       = 1'b1;
                  end
                  CMD_SCW: begin
                     hold_d  = pack_cmd(host.host_cmd, host.host_addr, host.host_tag);
                     beat_d  = '0;
                     state_d = ST_WDATA;
                  end
                  default: err_d = 1'b1;
               endcase
            end
         end
         ST_WDATA: begin
            wdat_rdy = !reset;
            if (host.host_wdata_valid && wdat_rdy) begin
               dat_push = 1'b1;
               beat_d   = beat_q + 1'b1;
               if (beat_q == BW'(BURST - 1)) state_d = ST_PUSH;
            end
         end
         ST_PUSH: begin
            // Data is fully buffered; publishing the command now keeps it behind its data
            cmd_push = 1'b1;
            wr_done  = 1'b1;
            state_d  = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // FSM and holding registers
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
         hold_q  <= '0;
         beat_q  <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         hold_q  <= hold_d;
         beat_q  <= beat_d;
         err_q   <= err_d;
      end
   end

   assign host.host_cmd_ready   = cmd_rdy;
   assign host.host_wdata_ready = wdat_rdy;
   assign host.host_err         = err_q;

   ddr3_sync_fifo #(.WIDTH(CW_WIDTH), .DEPTH(CMD_DEPTH)) u_cmd_fifo (
      .clk      (clk),
      .reset    (reset),
      .push     (cmd_push),
      .push_dat (cmd_push_dat),
      .pop      (CMD_get),
      .pop_dat  (CMD_data_out),
      .count    (unused_cmd_count),
      .full     (cmd_full),
      .empty    (CMD_empty)
   );

   ddr3_sync_fifo #(.WIDTH(16), .DEPTH(DATA_DEPTH)) u_data_fifo (
      .clk      (clk),
      .reset    (reset),
      .push     (dat_push),
      .push_dat (host.host_wdata),
      .pop      (DATA_get),
      .pop_dat  (DATA_data_out),
      .count    (data_count),
      .full     (unused_data_full),
      .empty    (unused_data_empty)
   );

`ifdef DDR3_FE_STATS_EN
   logic [15:0] rd_cnt_q, rd_cnt_d, wr_cnt_q, wr_cnt_d;

   // Saturating event counters
   always_comb begin
      rd_cnt_d = rd_cnt_q;
      wr_cnt_d = wr_cnt_q;
      if (rd_acc && (rd_cnt_q != 16'hFFFF)) rd_cnt_d = rd_cnt_q + 16'd1;
      if (wr_done && (wr_cnt_q != 16'hFFFF)) wr_cnt_d = wr_cnt_q + 16'd1;
   end

   // Counter registers
   always_ff @(posedge clk) begin
      if (reset) begin
         rd_cnt_q <= '0;
         wr_cnt_q <= '0;
      end else begin
         rd_cnt_q <= rd_cnt_d;
         wr_cnt_q <= wr_cnt_d;
      end
   end

   assign stat_rd_cnt = rd_cnt_q;
   assign stat_wr_cnt = wr_cnt_q;
`else
   logic unused_stat_evt;
   assign unused_stat_evt = rd_acc ^ wr_done;
   assign stat_rd_cnt     = '0;
   assign stat_wr_cnt     = '0;
`endif

endmodule

// File: tb/tb_ddr3_host_frontend.sv
// Bench for ddr3_host_frontend: table of single requests plus full/wrap/illegal/reset sequences.
// Expected command words and beats come from a scoreboard filled as stimulus is driven.
// DUT built with DATA_DEPTH = 16 so data-FIFO space and wrap are reachable quickly.
module tb_ddr3_host_frontend;

   localparam logic [2:0] C_SCR = 3'b001;
   localparam logic [2:0] C_SCW = 3'b010;

   logic        clk = 1'b0;
   logic        reset;
   logic        CMD_get, DATA_get;
   logic        CMD_empty;
   logic [33:0] CMD_data_out;
   logic [15:0] DATA_data_out, stat_rd_cnt, stat_wr_cnt;

   ddr3_host_frontend_if ifc ();

   ddr3_host_frontend #(.CMD_DEPTH(8), .DATA_DEPTH(16), .BURST(8)) dut (
      .clk           (clk),
      .reset         (reset),
      .host          (ifc),
      .CMD_get       (CMD_get),
      .CMD_empty     (CMD_empty),
      .CMD_data_out  (CMD_data_out),
      .DATA_get      (DATA_get),
      .DATA_data_out (DATA_data_out),
      .stat_rd_cnt   (stat_rd_cnt),
      .stat_wr_cnt   (stat_wr_cnt)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;
   int exp_rd = 0;
   int exp_wr = 0;
   logic [33:0] exp_cmd_q [$];
   logic [15:0] exp_dat_q [$];

   typedef struct {
      logic [2:0]  cmd;
      logic [25:0] addr;
      logic [4:0]  tag;
      logic [15:0] wbase;
      logic        exp_err;
      logic        exp_vis;
   } vec_t;

   vec_t vecs [9];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_stats(input string name);
`ifdef DDR3_FE_STATS_EN
      check({name, "_rd_cnt"}, 64'(stat_rd_cnt), 64'(exp_rd));
      check({name, "_wr_cnt"}, 64'(stat_wr_cnt), 64'(exp_wr));
`else
      check({name, "_rd_cnt"}, 64'(stat_rd_cnt), 64'd0);
      check({name, "_wr_cnt"}, 64'(stat_wr_cnt), 64'd0);
`endif
   endtask

   // Returns one cycle after the accept edge
   task automatic send_cmd(input logic [2:0] c, input logic [25:0] a, input logic [4:0] t);
      int n = 0;
      ifc.host_cmd_valid = 1'b1;
      ifc.host_cmd       = c;
      ifc.host_addr      = a;
      ifc.host_tag       = t;
      while (!ifc.host_cmd_ready && n < 50) begin
         tick();
         n++;
      end
      if (!ifc.host_cmd_ready) begin
         check("cmd_accept_timeout", 64'(ifc.host_cmd_ready), 64'd1);
         ifc.host_cmd_valid = 1'b0;
         return;
      end
      if (c == C_SCR) begin
         exp_cmd_q.push_back({c, a, t});
         exp_rd++;
      end
      tick();
      ifc.host_cmd_valid = 1'b0;
   endtask

   task automatic send_beats(input logic [15:0] base, input int cnt);
      for (int i = 0; i < cnt; i++) begin
         int n = 0;
         ifc.host_wdata_valid = 1'b1;
         ifc.host_wdata       = base + 16'(i);
         while (!ifc.host_wdata_ready && n < 50) begin
            tick();
            n++;
         end
         if (!ifc.host_wdata_ready) begin
            check("beat_accept_timeout", 64'(ifc.host_wdata_ready), 64'd1);
            ifc.host_wdata_valid = 1'b0;
            return;
         end
         exp_dat_q.push_back(base + 16'(i));
         tick();
      end
      ifc.host_wdata_valid = 1'b0;
   endtask

   task automatic do_write(input logic [25:0] a, input logic [4:0] t, input logic [15:0] base,
                           input string name);
      bit was_empty;
      was_empty = (exp_cmd_q.size() == 0);
      send_cmd(C_SCW, a, t);
      check({name, "_err"}, 64'(ifc.host_err), 64'd0);
      send_beats(base, 8);
      // PUSH cycle: command not yet visible, both readies low
      if (was_empty) check({name, "_push_empty"}, 64'(CMD_empty), 64'd1);
      check({name, "_push_wrdy"}, 64'(ifc.host_wdata_ready), 64'd0);
      check({name, "_push_crdy"}, 64'(ifc.host_cmd_ready), 64'd0);
      exp_cmd_q.push_back({C_SCW, a, t});
      exp_wr++;
      tick();
      check({name, "_cmd_vis"}, 64'(CMD_empty), 64'd0);
   endtask

   task automatic pop_cmd(input string name);
      logic [33:0] e;
      check({name, "_not_empty"}, 64'(CMD_empty), 64'd0);
      CMD_get = 1'b1;
      tick();
      CMD_get = 1'b0;
      e = exp_cmd_q.pop_front();
      check({name, "_word"}, 64'(CMD_data_out), 64'(e));
      check({name, "_empty_after"}, 64'(CMD_empty), 64'(exp_cmd_q.size() == 0));
   endtask

   task automatic pop_dat(input string name);
      logic [15:0] e;
      DATA_get = 1'b1;
      tick();
      DATA_get = 1'b0;
      e = exp_dat_q.pop_front();
      check(name, 64'(DATA_data_out), 64'(e));
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err + 1);
      $fatal(1);
   end

   initial begin
      vecs[0] = '{C_SCR,  26'h1234567, 5'd5,  16'h0,    1'b0, 1'b1};
      vecs[1] = '{C_SCR,  26'h3FFFFFF, 5'd31, 16'h0,    1'b0, 1'b1};
      vecs[2] = '{C_SCW,  26'h0000000, 5'd0,  16'hA000, 1'b0, 1'b1};
      vecs[3] = '{3'b111, 26'h0ABCDEF, 5'd7,  16'h0,    1'b1, 1'b0};
      vecs[4] = '{3'b000, 26'h0000001, 5'd1,  16'h0,    1'b1, 1'b0};
      vecs[5] = '{C_SCR,  26'h2AAAAAA, 5'd10, 16'h0,    1'b0, 1'b1};
      vecs[6] = '{C_SCW,  26'h1555555, 5'd21, 16'h5500, 1'b0, 1'b1};
      vecs[7] = '{3'b011, 26'h1000000, 5'd3,  16'h0,    1'b1, 1'b0};
      vecs[8] = '{3'b100, 26'h0FFFFFF, 5'd9,  16'h0,    1'b1, 1'b0};

      reset = 1'b1;
      CMD_get = 1'b0;
      DATA_get = 1'b0;
      ifc.host_cmd_valid = 1'b0;
      ifc.host_cmd = '0;
      ifc.host_addr = '0;
      ifc.host_tag = '0;
      ifc.host_wdata_valid = 1'b0;
      ifc.host_wdata = '0;
      tick();
      tick();
      check("rst_cmd_ready", 64'(ifc.host_cmd_ready), 64'd0);
      check("rst_wdata_ready", 64'(ifc.host_wdata_ready), 64'd0);
      check("rst_err", 64'(ifc.host_err), 64'd0);
      check("rst_cmd_empty", 64'(CMD_empty), 64'd1);
      check("rst_cmd_data", 64'(CMD_data_out), 64'd0);
      check("rst_data_data", 64'(DATA_data_out), 64'd0);
      check_stats("rst");
      reset = 1'b0;
      tick();
      check("idle_cmd_ready", 64'(ifc.host_cmd_ready), 64'd1);

      // Table of single requests
      for (int i = 0; i < 9; i++) begin
         string nm;
         nm = $sformatf("v%0d", i);
         if (vecs[i].cmd == C_SCW) begin
            do_write(vecs[i].addr, vecs[i].tag, vecs[i].wbase, nm);
            pop_cmd(nm);
            for (int b = 0; b < 8; b++) pop_dat($sformatf("%s_beat%0d", nm, b));
         end else begin
            send_cmd(vecs[i].cmd, vecs[i].addr, vecs[i].tag);
            check({nm, "_err"}, 64'(ifc.host_err), 64'(vecs[i].exp_err));
            check({nm, "_empty"}, 64'(CMD_empty), 64'(!vecs[i].exp_vis));
            tick();
            check({nm, "_err_next"}, 64'(ifc.host_err), 64'd0);
            if (vecs[i].exp_vis) pop_cmd(nm);
            else check({nm, "_still_empty"}, 64'(CMD_empty), 64'd1);
         end
         check_stats(nm);
      end

      // Command FIFO full: eight back-to-back reads
      for (int i = 0; i < 8; i++) send_cmd(C_SCR, 26'h0100000 + 26'(i), 5'(i + 2));
      check("cfull_ready", 64'(ifc.host_cmd_ready), 64'd0);
      tick();
      check("cfull_ready_hold", 64'(ifc.host_cmd_ready), 64'd0);
      pop_cmd("cfull_pop0");
      check("cfull_ready_after_pop", 64'(ifc.host_cmd_ready), 64'd1);
      for (int i = 1; i < 8; i++) pop_cmd($sformatf("cfull_pop%0d", i));
      // Output holds and a get on empty changes nothing
      tick();
      check("cmd_hold", 64'(CMD_data_out), 64'({C_SCR, 26'h0100007, 5'd9}));
      CMD_get = 1'b1;
      tick();
      CMD_get = 1'b0;
      check("cmd_get_on_empty", 64'(CMD_data_out), 64'({C_SCR, 26'h0100007, 5'd9}));
      check("cmd_get_on_empty_flag", 64'(CMD_empty), 64'd1);
      check_stats("cfull");

      // Data FIFO space and pointer wrap
      do_write(26'h0200000, 5'd11, 16'hB000, "dw0");
      do_write(26'h0300000, 5'd12, 16'hB100, "dw1");
      check("dfull_ready", 64'(ifc.host_cmd_ready), 64'd0);
      for (int b = 0; b < 7; b++) pop_dat($sformatf("dfull_beat%0d", b));
      check("dfull_ready_7pops", 64'(ifc.host_cmd_ready), 64'd0);
      pop_dat("dfull_beat7");
      check("dfull_ready_8pops", 64'(ifc.host_cmd_ready), 64'd1);
      do_write(26'h0400000, 5'd13, 16'hC000, "dw2");
      for (int i = 0; i < 3; i++) pop_cmd($sformatf("wrap_cmd%0d", i));
      for (int b = 0; b < 16; b++) pop_dat($sformatf("wrap_beat%0d", b));
      check_stats("wrap");

      // Reset in the middle of a write burst
      send_cmd(C_SCW, 26'h0500000, 5'd14);
      send_beats(16'hD000, 4);
      reset = 1'b1;
      tick();
      check("mrst_cmd_ready", 64'(ifc.host_cmd_ready), 64'd0);
      check("mrst_wdata_ready", 64'(ifc.host_wdata_ready), 64'd0);
      check("mrst_empty", 64'(CMD_empty), 64'd1);
      tick();
      exp_dat_q.delete();
      exp_cmd_q.delete();
      exp_rd = 0;
      exp_wr = 0;
      reset = 1'b0;
      tick();
      check("mrst_cmd_data", 64'(CMD_data_out), 64'd0);
      check("mrst_data_data", 64'(DATA_data_out), 64'd0);
      check("mrst_idle_ready", 64'(ifc.host_cmd_ready), 64'd1);
      check_stats("mrst");
      DATA_get = 1'b1;
      tick();
      DATA_get = 1'b0;
      check("mrst_data_get_empty", 64'(DATA_data_out), 64'd0);
      do_write(26'h0600000, 5'd15, 16'hE000, "post_rst");
      pop_cmd("post_rst");
      for (int b = 0; b < 8; b++) pop_dat($sformatf("post_rst_beat%0d", b));
      check_stats("final");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/ddr3_host_frontend.md
# ddr3_host_frontend

Host-side request front end for the DDR3 controller. It accepts single-burst read and write requests over a valid/ready handshake and collects eight write-data beats per write. It packs each request into the 34-bit command word and buffers commands and write data in two synchronous FIFOs. The FIFOs are drained by the DDR3 processing logic through `CMD_get`/`CMD_empty`/`CMD_data_out` and `DATA_get`/`DATA_data_out`.

## Interface
Parameters:
- `CMD_DEPTH`, default 8: command FIFO entries; power of two.
- `DATA_DEPTH`, default 64: write-data FIFO entries; power of two, ≥ `BURST`.
- `BURST`, default 8: data beats per write command.

Ports:
- `clk`, input, 1: sole clock, rising edge.
- `reset`, input, 1: synchronous, active-high.
- `host_cmd_valid`, input, 1: request present.
- `host_cmd_ready`, output, 1: request accepted when valid && ready.
- `host_cmd`, input, 3: command code; 001 = SCR (read), 010 = SCW (write).
- `host_addr`, input, 26: {BA[2:0], row[12:0], col[9:0]}.
- `host_tag`, input, 5: opaque tag, placed in word bits [4:0].
- `host_wdata_valid`, input, 1: write beat present.
- `host_wdata_ready`, output, 1: beat accepted when valid && ready.
- `host_wdata`, input, 16: write beat.
- `host_err`, output, 1: one-cycle pulse when an illegal command code is accepted.
- `CMD_get`, input, 1: pop command FIFO.
- `CMD_empty`, output, 1: command FIFO empty.
- `CMD_data_out`, output, 34: {cmd[2:0], addr[25:0], tag[4:0]}.
- `DATA_get`, input, 1: pop data FIFO.
- `DATA_data_out`, output, 16: popped write beat.
- `stat_rd_cnt`, output, 16: accepted reads (see Configuration).
- `stat_wr_cnt`, output, 16: completed writes (see Configuration).

## Operation
- FSM states: IDLE, WDATA, PUSH.
- **IDLE**
  - `host_cmd_ready` = !cmd_full && data_free ≥ `BURST`. It does not depend on `host_cmd`.
  - Accepted SCR: the word is written into the command FIFO on the same edge. The state stays IDLE.
  - Accepted SCW: the word is latched into a holding register, the beat counter is cleared, and the state goes to WDATA.
  - Accepted code other than 001/010: the request is dropped, `host_err` pulses the next cycle, and the state stays IDLE.
- **WDATA**
  - `host_cmd_ready` = 0 and `host_wdata_ready` = 1.
  - Each accepted beat is pushed into the data FIFO and the 3-bit beat counter increments.
  - On the `BURST`-th beat the state goes to PUSH.
  - `host_wdata_ready` is 0 in every other state.
- **PUSH**
  - The holding word is written into the command FIFO, then the state returns to IDLE.
  - A command is therefore never visible before all of its data is buffered.
  - Space is guaranteed by the IDLE ready condition, because only this FSM writes the FIFOs.
- **FIFO read**
  - A registered read: `CMD_get` (or `DATA_get`) while not empty loads the head entry into the output register on the same edge, so it is visible the next cycle.
  - The output holds its value until the next successful pop.
  - A get on an empty FIFO is ignored: no pointer or output change.
- Simultaneous push and pop on one FIFO are both performed; the occupancy count is unchanged.
- Pointers wrap modulo depth. Occupancy is a counter of width clog2(depth)+1.

## Timing
- Reset values:
  - `host_cmd_ready` 0 during reset.
  - `host_wdata_ready` 0, `host_err` 0.
  - `CMD_empty` 1, `CMD_data_out` 0, `DATA_data_out` 0.
  - Stat counters 0.
  - State IDLE; all pointers and counts 0.
- Reset mid-write discards partial beats and the held word.
- Read latency: accept edge N → `CMD_empty` = 0 in cycle N+1.
- Write latency: last beat accepted at edge N → PUSH in cycle N+1 → `CMD_empty` = 0 in cycle N+2.
- Minimum write occupancy on the host: 1 command cycle + `BURST` beat cycles + 1 PUSH cycle. Back-to-back reads are accepted one per cycle.
- `CMD_empty` and `DATA` full/empty flags are registered from the counts and updated on the push/pop edge.

## Configuration
- `DDR3_FE_STATS_EN` defined:
  - `stat_rd_cnt` increments on each accepted SCR.
  - `stat_wr_cnt` increments on each PUSH.
  - Both are 16-bit and saturate at 0xFFFF.
- Not defined: the counters are not synthesised and both ports are tied to 0.

## Structure
- Package `ddr3_pkg`:
  - Command codes SCR = 3'b001, SCW = 3'b010.
  - Command-word field positions: cmd [33:31], BA [30:28], row [27:15], col [14:5], tag [4:0].
  - `BURST` default value.
- One sub-module, `ddr3_sync_fifo`: parameterised width and depth, registered read, count, full, empty. It is instantiated twice: 34×`CMD_DEPTH` and 16×`DATA_DEPTH`.

## Test plan
- **Single read:** SCR, addr 0x1234567, tag 5 → `CMD_empty` falls one cycle after accept. `CMD_get` → `CMD_data_out` = {001, 0x1234567, 5'd5} the next cycle.
- **Single write:** SCW plus 8 beats 0xA000..0xA007 → command visible two cycles after the last beat. Eight `DATA_get` pulses return 0xA000..0xA007 in order.
- **Command-FIFO full:** 8 reads with no gets → ready = 0 on the 9th. One `CMD_get` → ready = 1 the next cycle.
- **Data-FIFO space and wrap:** with `DATA_DEPTH` = 16, 2 writes with no gets → ready = 0. Pop 8 beats, then a third write completes with pointers wrapped and data intact.
- **Illegal code:** code 3'b111 → dropped, one-cycle `host_err`, `CMD_empty` stays 1. With `DDR3_FE_STATS_EN`, the counts are unchanged.
- **Reset mid-write:** reset after 4 beats → `CMD_empty` = 1 and all FIFO counts 0. The next SCW is accepted normally.
